decode_ctrl_pipe: RTL and testbench

Parametrised, registered RV32I/RV64I instruction-to-control decoder for the front end. It accepts up to LANES instructions per cycle on a valid/ready handshake and decodes each into a 22-bit control word. Results are held in a two-entry skid buffer so that back-pressure never drops or duplicates a bundle. This is the successor of the combinational controllers: it adds lane width, pipelining, flush, illegal-instruction accounting and optional RV64 word-op decode.

---
 rtl/decode_ctrl_pipe.sv | 246 ++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I/RV64I instruction-to-control decoder.
// Accepts LANES instructions per bundle and buffers the decoded bundles in a two-entry
// skid buffer. Keeps a saturating count of the illegal lanes it accepts.
// Optional feature: define DECODE_RV64_EN to decode OP-IMM-32 / OP-32 word ops.
// The same macro also admits LD, LWU and SD.
module decode_ctrl_pipe #(
    parameter int unsigned LANES     = 1,
    parameter int unsigned ILL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_insn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [22*LANES-1:0]   out_ctrl,
    output logic [ILL_CNT_W-1:0]  ill_count
);

`ifdef DECODE_RV64_EN
    localparam bit Rv64En = 1'b1;
`else
    localparam bit Rv64En = 1'b0;
`endif

    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6F;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpImm32  = 7'h1B;
    localparam logic [6:0] OpReg32  = 7'h3B;

    localparam logic [2:0] ImmNone = 3'd0;
    localparam logic [2:0] ImmI    = 3'd1;
    localparam logic [2:0] ImmS    = 3'd2;
    localparam logic [2:0] ImmB    = 3'd3;
    localparam logic [2:0] ImmU    = 3'd4;
    localparam logic [2:0] ImmJ    = 3'd5;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassb = 4'd10;

    localparam logic [21:0] CtrlIllegal = 22'h200000;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    // funct3 to ALU op; alt selects SUB/SRA (funct7 bit 5).
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? AluSub : AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = alt ? AluSra : AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [21:0] decode_insn(input logic [31:0] insn);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [6:0] f7s;
        logic       ill, word, rw, mr, mw, br, jp, imm, pc, rs2;
        logic [2:0] isel;
        logic [3:0] alu;
        opc  = insn[6:0];
        f3   = insn[14:12];
        f7   = insn[31:25];
        f7s  = f7;
        ill  = 1'b0;
        word = 1'b0;
        rw   = 1'b0;
        mr   = 1'b0;
        mw   = 1'b0;
        br   = 1'b0;
        jp   = 1'b0;
        imm  = 1'b0;
        pc   = 1'b0;
        rs2  = 1'b0;
        isel = ImmNone;
        alu  = AluAdd;
        case (opc)
            OpLui:   begin isel = ImmU; alu = AluPassb; rw = 1'b1; imm = 1'b1; end
            OpAuipc: begin isel = ImmU; rw = 1'b1; imm = 1'b1; pc = 1'b1; end
            // JAL targets are PC-relative (J immediate); JALR is register + I immediate.
            OpJal:   begin isel = ImmJ; rw = 1'b1; jp = 1'b1; imm = 1'b1; pc = 1'b1; end
            OpJalr: begin
                isel = ImmI; rw = 1'b1; jp = 1'b1; imm = 1'b1;
                ill  = (f3 != 3'd0);
            end
            OpBranch: begin
                isel = ImmB; br = 1'b1; rs2 = 1'b1;
                case (f3)
                    3'd0, 3'd1: alu = AluSub;
                    3'd4, 3'd5: alu = AluSlt;
                    3'd6, 3'd7: alu = AluSltu;
                    default:    ill = 1'b1;
                endcase
            end
            OpLoad: begin
                isel = ImmI; rw = 1'b1; mr = 1'b1; imm = 1'b1;
                ill  = (f3 == 3'd7) || (!Rv64En && (f3 == 3'd3 || f3 == 3'd6));
            end
            OpStore: begin
                isel = ImmS; mw = 1'b1; imm = 1'b1; rs2 = 1'b1;
                ill  = (f3 > 3'd3) || (!Rv64En && f3 == 3'd3);
            end
            OpImm, OpImm32: begin
                word = (opc == OpImm32);
                // RV64 full-width shifts carry a 6-bit shamt, so funct7 bit 0 is shamt[5].
                f7s  = (Rv64En && !word) ? {f7[6:1], 1'b0} : f7;
                isel = ImmI; rw = 1'b1; imm = 1'b1;
                alu  = alu_of(f3, (f3 == 3'd5) && f7s[5]);
                case (f3)
                    3'd0:    ill = 1'b0;
                    3'd1:    ill = (f7s != 7'h00);
                    3'd5:    ill = (f7s != 7'h00) && (f7s != 7'h20);
                    default: ill = word;
                endcase
                if (word && !Rv64En) ill = 1'b1;
            end
            OpReg, OpReg32: begin
                word = (opc == OpReg32);
                rw   = 1'b1; rs2 = 1'b1;
                alu  = alu_of(f3, f7[5]);
                if (f7 == 7'h00)      ill = word && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
                else if (f7 == 7'h20) ill = !(f3 == 3'd0 || f3 == 3'd5);
                else                  ill = 1'b1;
                if (word && !Rv64En) ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) return CtrlIllegal;
        return {1'b0, word, (rw ? insn[11:7] : 5'd0), isel, alu,
                rw, mr, mw, br, jp, imm, pc, rs2};
    endfunction

    state_e                 state_q, state_d;
    logic [22*LANES-1:0]    head_q, head_d, tail_q, tail_d, dec_bundle;
    logic                   in_ready_q;
    logic [ILL_CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic [2:0]             n_ill;
    logic [ILL_CNT_W+2:0]   cnt_sum;
    logic                   acc, pop;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_ctrl  = head_q;
    assign ill_count = ill_cnt_q;
    assign acc       = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready;

    // Decode every lane of the offered bundle.
    always_comb begin
        dec_bundle = '0;
        n_ill      = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            dec_bundle[22*i +: 22] = decode_insn(in_insn[32*i +: 32]);
            n_ill = n_ill + {2'b00, dec_bundle[22*i+21]};
        end
    end

    // Saturating illegal-lane counter, bumped only by accepted bundles.
    always_comb begin
        cnt_sum   = {3'b000, ill_cnt_q} + {{ILL_CNT_W{1'b0}}, n_ill};
        ill_cnt_d = ill_cnt_q;
        if (acc) begin
            ill_cnt_d = (|cnt_sum[ILL_CNT_W+2:ILL_CNT_W]) ? '1 : cnt_sum[ILL_CNT_W-1:0];
        end
    end

    // Skid-buffer occupancy and data movement.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        head_d  = dec_bundle;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (acc && pop) begin
                        head_d = dec_bundle;
                    end else if (acc) begin
                        tail_d  = dec_bundle;
                        state_d = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State registers; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            ill_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != StTwo);
            ill_cnt_q  <= ill_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios plus randomized traffic
// against a mask/match instruction table and a queue-based buffer model.
module tb_decode_ctrl_pipe;

    localparam int unsigned LANES     = 4;
    localparam int unsigned ILL_CNT_W = 4;
    localparam int unsigned IW        = 32 * LANES;
    localparam int unsigned CW        = 22 * LANES;
    localparam logic [31:0] NOP       = 32'h0000_0013;

`ifdef DECODE_RV64_EN
    localparam logic [21:0] ExpFirst = 22'h141084;
    localparam int          ExpIll1  = 0;
    localparam logic [31:0] ShMask   = 32'hFC00707F;
`else
    localparam logic [21:0] ExpFirst = 22'h200000;
    localparam int          ExpIll1  = 1;
    localparam logic [31:0] ShMask   = 32'hFE00707F;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0]        in_insn;
    logic [CW-1:0]        out_ctrl;
    logic [ILL_CNT_W-1:0] ill_count;

    decode_ctrl_pipe #(.LANES(LANES), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .ill_count (ill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [21:0] tmpl;
    } entry_t;

    entry_t        tbl[$];
    logic [CW-1:0] sb[$];
    int            m_cnt;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic word, input int isel, input int alu,
                                       input logic [7:0] flags);
        return {1'b0, word, 5'd0, 3'(isel), 4'(alu), flags};
    endfunction

    task automatic add_e(input logic [31:0] mask, input logic [31:0] match,
                         input logic [21:0] tmpl);
        entry_t e;
        e.mask  = mask;
        e.match = match;
        e.tmpl  = tmpl;
        tbl.push_back(e);
    endtask

    // ISA table: flags byte = {rw, mem_rd, mem_wr, br, jump, imm, pc, rs2}.
    task automatic build_table();
        int ld[$];
        int st[$];
        int oi_f3[6];
        int oi_alu[6];
        int op_alu[10];
        logic [31:0] op_match[10];
        ld = '{0, 1, 2, 4, 5};
        st = '{0, 1, 2};
`ifdef DECODE_RV64_EN
        ld.push_back(3);
        ld.push_back(6);
        st.push_back(3);
`endif
        add_e(32'h7F, 32'h37, mk(0, 4, 10, 8'h84));
        add_e(32'h7F, 32'h17, mk(0, 4, 0, 8'h86));
        add_e(32'h7F, 32'h6F, mk(0, 5, 0, 8'h8E));
        add_e(32'h707F, 32'h67, mk(0, 1, 0, 8'h8C));
        for (int f = 0; f < 8; f++) begin
            if (f != 2 && f != 3)
                add_e(32'h707F, 32'h63 | (32'(f) << 12), mk(0, 3, (f < 2) ? 1 : (f < 6) ? 3 : 4,
                                                           8'h11));
        end
        foreach (ld[k]) add_e(32'h707F, 32'h03 | (32'(ld[k]) << 12), mk(0, 1, 0, 8'hC4));
        foreach (st[k]) add_e(32'h707F, 32'h23 | (32'(st[k]) << 12), mk(0, 2, 0, 8'h25));
        oi_f3  = '{0, 2, 3, 4, 6, 7};
        oi_alu = '{0, 3, 4, 5, 8, 9};
        for (int k = 0; k < 6; k++)
            add_e(32'h707F, 32'h13 | (32'(oi_f3[k]) << 12), mk(0, 1, oi_alu[k], 8'h84));
        add_e(ShMask, 32'h0000_1013, mk(0, 1, 2, 8'h84));
        add_e(ShMask, 32'h0000_5013, mk(0, 1, 6, 8'h84));
        add_e(ShMask, 32'h4000_5013, mk(0, 1, 7, 8'h84));
        op_match = '{32'h33, 32'h4000_0033, 32'h1033, 32'h2033, 32'h3033, 32'h4033,
                     32'h5033, 32'h4000_5033, 32'h6033, 32'h7033};
        op_alu   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        for (int k = 0; k < 10; k++) add_e(32'hFE00707F, op_match[k], mk(0, 0, op_alu[k], 8'h81));
`ifdef DECODE_RV64_EN
        add_e(32'h707F, 32'h1B, mk(1, 1, 0, 8'h84));
        add_e(32'hFE00707F, 32'h0000_101B, mk(1, 1, 2, 8'h84));
        add_e(32'hFE00707F, 32'h0000_501B, mk(1, 1, 6, 8'h84));
        add_e(32'hFE00707F, 32'h4000_501B, mk(1, 1, 7, 8'h84));
        add_e(32'hFE00707F, 32'h0000_003B, mk(1, 0, 0, 8'h81));
        add_e(32'hFE00707F, 32'h4000_003B, mk(1, 0, 1, 8'h81));
        add_e(32'hFE00707F, 32'h0000_103B, mk(1, 0, 2, 8'h81));
        add_e(32'hFE00707F, 32'h0000_503B, mk(1, 0, 6, 8'h81));
        add_e(32'hFE00707F, 32'h4000_503B, mk(1, 0, 7, 8'h81));
`endif
    endtask

    function automatic logic [21:0] ref_decode(input logic [31:0] insn);
        foreach (tbl[k]) begin
            if ((insn & tbl[k].mask) == tbl[k].match)
                return tbl[k].tmpl | (tbl[k].tmpl[7] ? {2'b00, insn[11:7], 15'd0} : 22'd0);
        end
        return 22'h200000;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  opcs[11];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
        r = $urandom();
        if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0:       r[31:25] = 7'h00;
            1:       r[31:25] = 7'h20;
            2:       r[31:26] = 6'h00;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_bundle();
        logic [IW-1:0] b;
        for (int i = 0; i < int'(LANES); i++) b[32*i +: 32] = rand_insn();
        return b;
    endfunction

    function automatic logic [IW-1:0] addi_bundle();
        logic [IW-1:0] b;
        for (int i = 0; i < int'(LANES); i++)
            b[32*i +: 32] = NOP | (32'($urandom_range(0, 31)) << 7);
        return b;
    endfunction

    // One clock: drive, compare against the model mid-cycle, advance the model, clock.
    task automatic cycle(input logic v, input logic [IW-1:0] insn, input logic rdy,
                         input logic fl);
        logic [CW-1:0] e;
        bit            acc, pop;
        int            n;
        in_valid  = v;
        in_insn   = insn;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check_eq("in_ready", in_ready, sb.size() < 2);
        check_eq("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) check_eq("out_ctrl", out_ctrl, sb[0]);
        check_eq("ill_count", ill_count, m_cnt);
        if (fl) begin
            sb.delete();
        end else begin
            acc = v && (sb.size() < 2);
            pop = rdy && (sb.size() != 0);
            if (pop) void'(sb.pop_front());
            if (acc) begin
                n = 0;
                for (int i = 0; i < int'(LANES); i++) begin
                    e[22*i +: 22] = ref_decode(insn[32*i +: 32]);
                    n += int'(e[22*i+21]);
                end
                sb.push_back(e);
                m_cnt = (m_cnt + n > 15) ? 15 : m_cnt + n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IW-1:0] illb;
        logic [IW-1:0] b;
        int            saved;
        n_checks  = 0;
        n_errors  = 0;
        m_cnt     = 0;
        build_table();
        illb      = {32'h0000_0597, 32'h0000_0000, 32'h0000_0093, 32'hFFFF_FFFF};
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_insn   = '0;
        #12;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_ctrl", out_ctrl, '0);
        check_eq("rst_ill_count", ill_count, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reference sequence on lane 0, legal NOPs on the other lanes.
        cycle(1'b1, {NOP, NOP, NOP, 32'h0010_041B}, 1'b1, 1'b0);
        check_eq("tp_first", out_ctrl[21:0], ExpFirst);
        check_eq("tp_ill1", ill_count, ExpIll1);
        cycle(1'b1, {NOP, NOP, NOP, 32'h0000_0597}, 1'b1, 1'b0);
        check_eq("tp_auipc", out_ctrl[21:0], 22'h05C086);
        cycle(1'b1, {NOP, NOP, NOP, 32'h0000_0093}, 1'b1, 1'b0);
        check_eq("tp_addi", out_ctrl[21:0], 22'h009084);
        check_eq("tp_nop_lane", out_ctrl[43:22], 22'h001084);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: two bundles fit, then in_ready drops; release drains in order.
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        check_eq("bp_full", in_ready, 1'b0);
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, addi_bundle(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in TWO with an illegal bundle offered: discarded and not counted.
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        saved = m_cnt;
        cycle(1'b1, illb, 1'b0, 1'b1);
        check_eq("fl_out_valid", out_valid, 1'b0);
        check_eq("fl_in_ready", in_ready, 1'b1);
        check_eq("fl_ill_count", ill_count, saved);

        // Mixed-legality bundle, then drive the counter into saturation.
        saved = m_cnt;
        cycle(1'b1, illb, 1'b1, 1'b0);
        check_eq("ill_lane0", out_ctrl[21:0], 22'h200000);
        check_eq("ill_lane1", out_ctrl[43:22], 22'h009084);
        check_eq("ill_lane2", out_ctrl[65:44], 22'h200000);
        check_eq("ill_lane3", out_ctrl[87:66], 22'h05C086);
        check_eq("ill_plus2", ill_count, saved + 2);
        for (int k = 0; k < 8; k++) cycle(1'b1, illb, 1'b1, 1'b0);
        check_eq("ill_sat", ill_count, 4'hF);

        // Asynchronous reset while holding two bundles.
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        cycle(1'b1, addi_bundle(), 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_out_ctrl", out_ctrl, '0);
        check_eq("arst_ill_count", ill_count, '0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        sb.delete();
        m_cnt = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic with varying back-pressure and occasional flush.
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 800; k++) begin
                b = rand_bundle();
                cycle($urandom_range(0, 3) != 0, b, $urandom_range(0, ph + 1) != 0,
                      $urandom_range(0, 39) == 0);
            end
            rst_n = 1'b0;
            sb.delete();
            m_cnt = 0;
            #2;
            rst_n = 1'b1;
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
